// File: rtl/ahb_apb_ctrl.sv
// ahb_apb_ctrl - AHB-to-APB bridge core for four APB slaves.
//
// Decodes each AHB single-word transfer into one of four APB slaves and
// runs exactly one APB SETUP and one ENABLE cycle per transfer. Outputs are
// registered (Moore). Reads complete in 2 cycles and writes in 3, because a
// write waits one cycle for Hwdata.
//
// Ports:
//   clock      - single clock, rising-edge
//   Hreset     - asynchronous active-high reset
//   Htrans     - AHB transfer type (only NONSEQ/SEQ start transfers)
//   Hreadyin   - AHB bus ready, qualifies the address phase
//   Hwrite     - AHB direction (1 = write)
//   Haddr      - AHB address
//   Hwdata     - AHB write data (data phase)
//   Prdata     - APB read data from the selected slave
//   Hreadyout  - transfer complete / no wait state
//   Hresp      - 00 OKAY, 01 ERROR
//   Hrdata     - read data to the master (combinational from Prdata)
//   Pselx      - one-hot APB slave select
//   Penable    - APB enable phase
//   Pwrite     - APB direction
//   Paddr      - APB address
//   Pwdata     - APB write data
//
// Optional feature macro: APB_ERR_RESP_EN
//   When defined, an AHB transfer outside the 4-slave window receives a
//   two-cycle ERROR response (ST_ERR1, ST_ERR2). When undefined such
//   transfers are silently ignored.
module ahb_apb_ctrl #(
  parameter int unsigned                ADDR_WIDTH  = 32,
  parameter int unsigned                DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0]      BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned                REGION_LOG2 = 26
) (
  input  logic                  clock,
  input  logic                  Hreset,
  input  logic [1:0]            Htrans,
  input  logic                  Hreadyin,
  input  logic                  Hwrite,
  input  logic [ADDR_WIDTH-1:0] Haddr,
  input  logic [DATA_WIDTH-1:0] Hwdata,
  input  logic [DATA_WIDTH-1:0] Prdata,
  output logic                  Hreadyout,
  output logic [1:0]            Hresp,
  output logic [DATA_WIDTH-1:0] Hrdata,
  output logic [3:0]            Pselx,
  output logic                  Penable,
  output logic                  Pwrite,
  output logic [ADDR_WIDTH-1:0] Paddr,
  output logic [DATA_WIDTH-1:0] Pwdata
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_SETUP,
    ST_ENABLE,
    ST_ERR1,
    ST_ERR2
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [1:0]            idx_q;

  logic                  inwin;
  logic [1:0]            idx;
  logic                  go;
  // Htrans[0] only distinguishes NONSEQ/SEQ and IDLE/BUSY, which both
  // collapse onto Htrans[1] for single-word transfers.
  logic                  trans_unused;
`ifdef APB_ERR_RESP_EN
  logic                  bad;
`endif

  function automatic logic [3:0] onehot(input logic [1:0] i);
    onehot = 4'b0001 << i;
  endfunction

  always_comb begin
    inwin = (Haddr[ADDR_WIDTH-1:REGION_LOG2+2] == BASE_ADDR[ADDR_WIDTH-1:REGION_LOG2+2]);
    idx   = Haddr[REGION_LOG2+1:REGION_LOG2];
    go    = Hreadyin & Htrans[1] & inwin;
`ifdef APB_ERR_RESP_EN
    bad   = Hreadyin & Htrans[1] & ~inwin;
`endif
    trans_unused = Htrans[0];
    Hrdata = Prdata;
  end

  // Outputs are loaded with the values of the state being entered, so every
  // output is a register yet still reflects the current state.
  always_ff @(posedge clock or posedge Hreset) begin
    if (Hreset) begin
      state     <= ST_IDLE;
      addr_q    <= '0;
      idx_q     <= '0;
      Pselx     <= '0;
      Penable   <= 1'b0;
      Pwrite    <= 1'b0;
      Paddr     <= '0;
      Pwdata    <= '0;
      Hreadyout <= 1'b1;
      Hresp     <= 2'b00;
    end else begin
      case (state)
        ST_IDLE, ST_ENABLE, ST_ERR2: begin
          Hresp <= 2'b00;
          if (go && !Hwrite) begin
            // Read needs no data phase: enter SETUP straight away.
            addr_q    <= Haddr;
            idx_q     <= idx;
            state     <= ST_SETUP;
            Pselx     <= onehot(idx);
            Penable   <= 1'b0;
            Pwrite    <= 1'b0;
            Paddr     <= Haddr;
            Hreadyout <= 1'b0;
          end else if (go && Hwrite) begin
            addr_q    <= Haddr;
            idx_q     <= idx;
            state     <= ST_WWAIT;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Hreadyout <= 1'b0;
`ifdef APB_ERR_RESP_EN
          end else if (bad) begin
            state     <= ST_ERR1;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Hreadyout <= 1'b0;
            Hresp     <= 2'b01;
`endif
          end else begin
            state     <= ST_IDLE;
            Pselx     <= '0;
            Penable   <= 1'b0;
            Hreadyout <= 1'b1;
          end
        end
        ST_WWAIT: begin
          state     <= ST_SETUP;
          Pselx     <= onehot(idx_q);
          Penable   <= 1'b0;
          Pwrite    <= 1'b1;
          Paddr     <= addr_q;
          Pwdata    <= Hwdata;
          Hreadyout <= 1'b0;
          Hresp     <= 2'b00;
        end
        ST_SETUP: begin
          state     <= ST_ENABLE;
          Penable   <= 1'b1;
          Hreadyout <= 1'b1;
          Hresp     <= 2'b00;
        end
        ST_ERR1: begin
          state     <= ST_ERR2;
          Pselx     <= '0;
          Penable   <= 1'b0;
          Hreadyout <= 1'b1;
          Hresp     <= 2'b01;
        end
        default: begin
          state     <= ST_IDLE;
          Pselx     <= '0;
          Penable   <= 1'b0;
          Hreadyout <= 1'b1;
          Hresp     <= 2'b00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ahb_apb_ctrl.sv
// tb_ahb_apb_ctrl - self-checking bench for ahb_apb_ctrl.
// Each started APB access pushes its expected select/direction/address/data
// onto a scoreboard; a monitor pops and compares on every ENABLE cycle.
module tb_ahb_apb_ctrl;

  logic        clock;
  logic        Hreset;
  logic [1:0]  Htrans;
  logic        Hreadyin;
  logic        Hwrite;
  logic [31:0] Haddr;
  logic [31:0] Hwdata;
  logic [31:0] Prdata;
  logic        Hreadyout;
  logic [1:0]  Hresp;
  logic [31:0] Hrdata;
  logic [3:0]  Pselx;
  logic        Penable;
  logic        Pwrite;
  logic [31:0] Paddr;
  logic [31:0] Pwdata;

  ahb_apb_ctrl #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .BASE_ADDR  (32'h8000_0000),
    .REGION_LOG2(26)
  ) dut (
    .clock    (clock),
    .Hreset   (Hreset),
    .Htrans   (Htrans),
    .Hreadyin (Hreadyin),
    .Hwrite   (Hwrite),
    .Haddr    (Haddr),
    .Hwdata   (Hwdata),
    .Prdata   (Prdata),
    .Hreadyout(Hreadyout),
    .Hresp    (Hresp),
    .Hrdata   (Hrdata),
    .Pselx    (Pselx),
    .Penable  (Penable),
    .Pwrite   (Pwrite),
    .Paddr    (Paddr),
    .Pwdata   (Pwdata)
  );

  typedef struct {
    logic [3:0]  sel;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   setup_cnt = 0;
  int   enable_cnt = 0;
  int   exp_setups = 0;
  int   exp_enables = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] slave_sel(input logic [31:0] a);
    logic [1:0] s;
    s = a[27:26];
    slave_sel = 4'b0001 << s;
  endfunction

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    exp_t e;
    e.sel  = slave_sel(addr);
    e.wr   = wr;
    e.addr = addr;
    e.data = data;
    sb.push_back(e);
    exp_setups++;
    exp_enables++;
  endtask

  task automatic drive_addr(input logic [1:0] tr, input logic wr, input logic [31:0] addr);
    Hreadyin = 1'b1;
    Htrans   = tr;
    Hwrite   = wr;
    Haddr    = addr;
  endtask

  // Full single transfer with latency measured in cycles after the address edge.
  task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] data);
    int  n;
    bit  done;
    drive_addr(2'b10, wr, addr);
    if (!wr) Prdata = data;
    push_exp(wr, addr, data);
    tick;
    Htrans = 2'b00;
    if (wr) Hwdata = data;
    n = 0;
    done = 0;
    while (!done && n < 10) begin
      @(negedge clock);
      n++;
      if (Hreadyout === 1'b1) done = 1;
    end
    check(wr ? "lat_write" : "lat_read", n, wr ? 3 : 2);
    tick;
  endtask

  // Scoreboard monitor: SETUP/ENABLE counting and ENABLE-cycle comparison.
  always @(negedge clock) begin
    if (!Hreset) begin
      if (Pselx != 4'b0000 && !Penable) setup_cnt++;
      if (Penable) begin
        enable_cnt++;
        if (sb.size() == 0) begin
          check("enable_unexpected", Penable, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("mon_psel", Pselx, e.sel);
          check("mon_pwrite", Pwrite, e.wr);
          check("mon_paddr", Paddr, e.addr);
          check("mon_ready", Hreadyout, 1);
          if (e.wr) check("mon_pwdata", Pwdata, e.data);
          else      check("mon_hrdata", Hrdata, e.data);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    Hreset   = 1'b1;
    Htrans   = 2'b00;
    Hreadyin = 1'b1;
    Hwrite   = 1'b0;
    Haddr    = '0;
    Hwdata   = '0;
    Prdata   = '0;

    // Reset state
    #2;
    check("rst_psel", Pselx, 0);
    check("rst_penable", Penable, 0);
    check("rst_pwrite", Pwrite, 0);
    check("rst_paddr", Paddr, 0);
    check("rst_pwdata", Pwdata, 0);
    check("rst_ready", Hreadyout, 1);
    check("rst_hresp", Hresp, 0);
    tick;
    tick;
    Hreset = 1'b0;
    tick;

    // Single read
    drive_addr(2'b10, 1'b0, 32'h8800_0004);
    Prdata = 32'hDEAD_BEEF;
    push_exp(1'b0, 32'h8800_0004, 32'hDEAD_BEEF);
    tick;
    Htrans = 2'b00;
    @(negedge clock);
    check("rd_setup_psel", Pselx, 4'b0100);
    check("rd_setup_pen", Penable, 0);
    check("rd_setup_ready", Hreadyout, 0);
    tick;
    @(negedge clock);
    check("rd_en_pen", Penable, 1);
    check("rd_en_ready", Hreadyout, 1);
    check("rd_en_hrdata", Hrdata, 32'hDEAD_BEEF);
    tick;
    @(negedge clock);
    check("rd_done_psel", Pselx, 0);
    tick;

    // Single write
    drive_addr(2'b10, 1'b1, 32'h8000_0020);
    push_exp(1'b1, 32'h8000_0020, 32'h1234_5678);
    tick;
    Htrans = 2'b00;
    Hwdata = 32'h1234_5678;
    @(negedge clock);
    check("wr_wait_ready", Hreadyout, 0);
    check("wr_wait_psel", Pselx, 0);
    tick;
    Hwdata = 32'hFFFF_FFFF;
    @(negedge clock);
    check("wr_setup_psel", Pselx, 4'b0001);
    check("wr_setup_pwrite", Pwrite, 1);
    check("wr_setup_pwdata", Pwdata, 32'h1234_5678);
    check("wr_setup_pen", Penable, 0);
    check("wr_setup_ready", Hreadyout, 0);
    tick;
    @(negedge clock);
    check("wr_en_pen", Penable, 1);
    check("wr_en_ready", Hreadyout, 1);
    tick;

    // Back-to-back: write 0x8C00_0000 then read 0x8400_0000 in its ENABLE
    drive_addr(2'b10, 1'b1, 32'h8C00_0000);
    push_exp(1'b1, 32'h8C00_0000, 32'hA5A5_0001);
    tick;
    Htrans = 2'b00;
    Hwdata = 32'hA5A5_0001;
    tick;
    @(negedge clock);
    check("b2b_w_setup_psel", Pselx, 4'b1000);
    check("b2b_w_setup_pen", Penable, 0);
    tick;
    drive_addr(2'b10, 1'b0, 32'h8400_0000);
    Prdata = 32'h0BAD_F00D;
    push_exp(1'b0, 32'h8400_0000, 32'h0BAD_F00D);
    @(negedge clock);
    check("b2b_w_en_psel", Pselx, 4'b1000);
    check("b2b_w_en_pen", Penable, 1);
    tick;
    Htrans = 2'b00;
    @(negedge clock);
    check("b2b_r_setup_psel", Pselx, 4'b0010);
    check("b2b_r_setup_pen", Penable, 0);
    tick;
    @(negedge clock);
    check("b2b_r_en_psel", Pselx, 4'b0010);
    check("b2b_r_en_pen", Penable, 1);
    tick;

    // Idle/busy filtering and Hreadyin low
    drive_addr(2'b00, 1'b0, 32'h8000_0000);
    tick;
    @(negedge clock);
    check("idle_psel", Pselx, 0);
    check("idle_ready", Hreadyout, 1);
    drive_addr(2'b01, 1'b1, 32'h8000_0000);
    tick;
    @(negedge clock);
    check("busy_psel", Pselx, 0);
    check("busy_ready", Hreadyout, 1);
    drive_addr(2'b10, 1'b0, 32'h8000_0000);
    Hreadyin = 1'b0;
    tick;
    @(negedge clock);
    check("nordy_psel", Pselx, 0);
    check("nordy_ready", Hreadyout, 1);
    Htrans   = 2'b00;
    Hreadyin = 1'b1;
    tick;

    // Out-of-window read
    drive_addr(2'b10, 1'b0, 32'h9000_0000);
    tick;
    Htrans = 2'b00;
    @(negedge clock);
`ifdef APB_ERR_RESP_EN
    check("oow_e1_hresp", Hresp, 2'b01);
    check("oow_e1_ready", Hreadyout, 0);
`else
    check("oow_c1_hresp", Hresp, 2'b00);
    check("oow_c1_ready", Hreadyout, 1);
`endif
    check("oow_c1_psel", Pselx, 0);
    tick;
    @(negedge clock);
`ifdef APB_ERR_RESP_EN
    check("oow_e2_hresp", Hresp, 2'b01);
`else
    check("oow_c2_hresp", Hresp, 2'b00);
`endif
    check("oow_c2_ready", Hreadyout, 1);
    check("oow_c2_psel", Pselx, 0);
    tick;
    @(negedge clock);
    check("oow_c3_hresp", Hresp, 2'b00);
    tick;

    // Reset mid-write during SETUP
    drive_addr(2'b10, 1'b1, 32'h8400_0010);
    exp_setups++;
    tick;
    Htrans = 2'b00;
    Hwdata = 32'h5555_AAAA;
    tick;
    @(negedge clock);
    check("rstw_setup_psel", Pselx, 4'b0010);
    #1;
    Hreset = 1'b1;
    #1;
    check("rstw_psel", Pselx, 0);
    check("rstw_pen", Penable, 0);
    check("rstw_ready", Hreadyout, 1);
    tick;
    Hreset = 1'b0;
    @(negedge clock);
    check("rstw_after_pen", Penable, 0);
    check("rstw_after_psel", Pselx, 0);
    tick;

    // Randomised single transfers across all four slaves
    for (int i = 0; i < 8; i++) begin
      logic        wr;
      logic [31:0] addr;
      logic [31:0] data;
      wr   = 1'($urandom_range(0, 1));
      addr = 32'h8000_0000 | (32'($urandom_range(0, 3)) << 26) | (32'($urandom_range(0, 255)) << 2);
      data = $urandom;
      do_xfer(wr, addr, data);
    end

    tick;
    check("sb_empty", sb.size(), 0);
    check("setup_count", setup_cnt, exp_setups);
    check("enable_count", enable_cnt, exp_enables);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ahb_apb_ctrl.md
Name: ahb_apb_ctrl

Overview:
AHB-to-APB bridge core. It sits between the AHB master-side signal group (Htrans, Haddr, Hwrite, Hwdata, Hreadyin) and the four APB slaves.
- Decodes and registers each AHB transfer.
- Runs the APB SETUP/ENABLE sequence and drives Pselx/Penable/Pwrite/Paddr/Pwdata.
- Returns Hreadyout/Hresp/Hrdata to the master.
- Single-word transfers only; Hsize/Hburst are not inputs.

Parameters:
ADDR_WIDTH, 32, width of Haddr/Paddr
DATA_WIDTH, 32, width of Hwdata/Hrdata/Pwdata/Prdata
BASE_ADDR, 32'h8000_0000, base of the 4-slave APB window
REGION_LOG2, 26, log2 of each slave's region size (64 MB)

Ports:
clock  in  1  single clock, all state updates on rising edge
Hreset  in  1  asynchronous, active-high reset
Htrans  in  2  AHB transfer type (IDLE 00, BUSY 01, NONSEQ 10, SEQ 11)
Hreadyin  in  1  AHB bus ready; address phase is sampled only when 1
Hwrite  in  1  1=write, 0=read
Haddr  in  ADDR_WIDTH  AHB address
Hwdata  in  DATA_WIDTH  AHB write data, valid in the data phase
Prdata  in  DATA_WIDTH  APB read data from the selected slave
Hreadyout  out  1  transfer-complete / no-wait-state indication
Hresp  out  2  00=OKAY, 01=ERROR
Hrdata  out  DATA_WIDTH  read data to the master
Pselx  out  4  one-hot APB slave select
Penable  out  1  APB enable phase
Pwrite  out  1  APB direction
Paddr  out  ADDR_WIDTH  APB address
Pwdata  out  DATA_WIDTH  APB write data

Behaviour:
- Reset (async, immediate, including mid-transfer):
  - state=ST_IDLE, Pselx=0, Penable=0, Pwrite=0, Paddr=0, Pwdata=0, Hreadyout=1, Hresp=00.
  - No partial APB access survives reset.
- Decode:
  - inwin = Haddr[ADDR_WIDTH-1:REGION_LOG2+2] == BASE_ADDR[ADDR_WIDTH-1:REGION_LOG2+2].
  - idx = Haddr[REGION_LOG2+1:REGION_LOG2].
  - With defaults: 0x8000_0000, 0x8400_0000, 0x8800_0000, 0x8C00_0000 select slaves 0..3.
- Transfer qualifiers:
  - go = Hreadyin & Htrans[1] & inwin.
  - IDLE and BUSY are never transfers.
- States: ST_IDLE, ST_WWAIT, ST_SETUP, ST_ENABLE, ST_ERR1, ST_ERR2. Moore outputs, all registered.
- Accepting states (ST_IDLE, ST_ENABLE, ST_ERR2), on a rising edge:
  - go & !Hwrite: latch Haddr and idx, go to ST_SETUP.
  - go & Hwrite: latch Haddr and idx, go to ST_WWAIT.
  - Otherwise: go to ST_IDLE.
- ST_WWAIT: Hreadyout=0; latch Hwdata; go to ST_SETUP.
- ST_SETUP:
  - Pselx=1<<idx, Pwrite=dir, Paddr=latched address, Pwdata=latched data, Penable=0, Hreadyout=0.
  - Go to ST_ENABLE.
- ST_ENABLE:
  - Pselx/Pwrite/Paddr/Pwdata held, Penable=1, Hreadyout=1.
  - A new address phase can be accepted in this same cycle (back-to-back).
- Outside SETUP/ENABLE: Pselx=0, Penable=0; Paddr/Pwdata hold their last values.
- Hrdata = Prdata (combinational); it is meaningful only in ST_ENABLE of a read.
- Hresp=00 in every state except ST_ERR1/ST_ERR2.
- Latency, counted from address-phase edge to completion:
  - Read: 2 cycles (one wait state).
  - Write: 3 cycles (two wait states).
- Back-to-back: each APB access has exactly one SETUP and one ENABLE cycle, never merged or skipped.

Optional Feature:
APB_ERR_RESP_EN
- Defined:
  - Hreadyin & Htrans[1] & !inwin in an accepting state goes to ST_ERR1 (Hreadyout=0, Hresp=01), then ST_ERR2 (Hreadyout=1, Hresp=01).
  - No APB signal toggles.
  - ST_ERR2 accepts the next transfer like ST_IDLE.
- Undefined:
  - Out-of-window transfers are ignored: stay in ST_IDLE, Hreadyout=1, Hresp=00, no APB access.
  - ST_ERR1/ST_ERR2 are not generated.

Test Plan:
- Reset mid-write: assert Hreset during ST_SETUP of a write to 0x8400_0010 -> same cycle Pselx=0, Penable=0, Hreadyout=1; no ENABLE cycle follows.
- Single read: NONSEQ read 0x8800_0004, Prdata=0xDEAD_BEEF -> SETUP Pselx=4'b0100, Penable=0; next cycle Penable=1, Hreadyout=1, Hrdata=0xDEAD_BEEF; 2-cycle completion.
- Single write: NONSEQ write 0x8000_0020, Hwdata=0x1234_5678 -> WWAIT (Hreadyout=0), SETUP Pselx=4'b0001, Pwrite=1, Pwdata=0x1234_5678, then ENABLE Penable=1, Hreadyout=1.
- Back-to-back: write 0x8C00_0000 followed, in its ENABLE cycle, by a read of 0x8400_0000 -> Pselx 4'b1000 for SETUP+ENABLE, then 4'b0010 for SETUP+ENABLE; no idle gap; Penable low in each SETUP.
- Idle/busy filtering: Htrans=00 then 01 at 0x8000_0000, and NONSEQ with Hreadyin=0 -> no Pselx assertion, Hreadyout stays 1.
- Out-of-window: NONSEQ read of 0x9000_0000 -> with APB_ERR_RESP_EN: Hresp=01 for 2 cycles, Hreadyout 0 then 1, Pselx=0; without it: Hresp=00, Hreadyout=1, Pselx=0.
